// File: rtl/instr_field_decoder_pkg.sv
// Shared instruction-format definitions: word/opcode widths, field bit positions,
// the decoded-field bundle and the slicing helper used by the field decoder.
package instr_field_decoder_pkg;

  localparam int INSTR_W  = 10;
  localparam int OPCODE_W = 4;
  localparam int ONEHOT_W = 1 << OPCODE_W;

  localparam int OPC_MSB  = 9;
  localparam int OPC_LSB  = 6;
  localparam int RI1_MSB  = 5;
  localparam int RI1_LSB  = 2;
  localparam int F51_MSB  = 5;
  localparam int F51_LSB  = 1;
  localparam int RI2_MSB  = 5;
  localparam int RI2_LSB  = 0;
  localparam int F10_MSB  = 1;
  localparam int F10_LSB  = 0;
  localparam int ARG2_BIT = 1;
  localparam int BIT0_BIT = 0;

  // Field slices overlap on purpose; each member is a raw copy of its bit range.
  typedef struct packed {
    logic [OPC_MSB-OPC_LSB:0] opcode;
    logic [RI1_MSB-RI1_LSB:0] ri1;
    logic [F51_MSB-F51_LSB:0] f51;
    logic [RI2_MSB-RI2_LSB:0] ri2;
    logic [F10_MSB-F10_LSB:0] f10;
    logic                     arg2;
    logic                     bit0;
  } decoded_instr_t;

  function automatic decoded_instr_t slice_fields(input logic [INSTR_W-1:0] instr);
    decoded_instr_t d;
    d.opcode = instr[OPC_MSB:OPC_LSB];
    d.ri1    = instr[RI1_MSB:RI1_LSB];
    d.f51    = instr[F51_MSB:F51_LSB];
    d.ri2    = instr[RI2_MSB:RI2_LSB];
    d.f10    = instr[F10_MSB:F10_LSB];
    d.arg2   = instr[ARG2_BIT];
    d.bit0   = instr[BIT0_BIT];
    return d;
  endfunction

endpackage

// File: rtl/instr_field_decoder_onehot.sv
// Combinational 4-to-16 opcode decoder; every opcode value maps to exactly one set bit.
module opcode_onehot_dec
  import instr_field_decoder_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic [ONEHOT_W-1:0] o_onehot
);

  assign o_onehot = {{(ONEHOT_W-1){1'b0}}, 1'b1} << i_opcode;

endmodule

// File: rtl/instr_field_decoder.sv
// Registered instruction field decoder: captures one instruction per valid cycle and
// presents its field slices plus a one-hot opcode one cycle later.
module instr_field_decoder
  import instr_field_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                out_valid,
  output logic [3:0]          opcode,
  output logic [3:0]          read_i1_write_i,
  output logic [4:0]          five_to_one,
  output logic [5:0]          read_i2_write_d_write_data,
  output logic [1:0]          one_to_zero,
  output logic                arg2,
  output logic                bit0,
  output logic [ONEHOT_W-1:0] opcode_onehot
);

  decoded_instr_t        w_dec;
  logic [ONEHOT_W-1:0]   w_onehot;
  decoded_instr_t        r_dec;
  logic [ONEHOT_W-1:0]   r_onehot;
  logic                  r_valid;

  assign w_dec = slice_fields(instr);

  opcode_onehot_dec u_onehot (
    .i_opcode (w_dec.opcode),
    .o_onehot (w_onehot)
  );

  // Reset wins over capture; fields hold when idle so an undriven instr cannot leak through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec    <= '0;
      r_onehot <= '0;
      r_valid  <= 1'b0;
    end else if (instr_valid) begin
      r_dec    <= w_dec;
      r_onehot <= w_onehot;
      r_valid  <= 1'b1;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign out_valid                  = r_valid;
  assign opcode                     = r_dec.opcode;
  assign read_i1_write_i            = r_dec.ri1;
  assign five_to_one                = r_dec.f51;
  assign read_i2_write_d_write_data = r_dec.ri2;
  assign one_to_zero                = r_dec.f10;
  assign arg2                       = r_dec.arg2;
  assign bit0                       = r_dec.bit0;
  assign opcode_onehot              = r_onehot;

endmodule

// File: tb/tb_instr_field_decoder.sv
// Self-checking bench for instr_field_decoder: directed plan steps followed by random
// traffic, compared against an arithmetic model of the instruction format.
module tb_instr_field_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  instr;
  logic        instr_valid;
  logic        out_valid;
  logic [3:0]  opcode;
  logic [3:0]  read_i1_write_i;
  logic [4:0]  five_to_one;
  logic [5:0]  read_i2_write_d_write_data;
  logic [1:0]  one_to_zero;
  logic        arg2;
  logic        bit0;
  logic [15:0] opcode_onehot;

  int n_vec = 0;
  int n_err = 0;

  // Model state: the last instruction value that the outputs should reflect.
  int m_instr  = 0;
  int m_valid  = 0;
  int m_onehot = 0;

  instr_field_decoder dut (
    .clk                        (clk),
    .rst                        (rst),
    .instr                      (instr),
    .instr_valid                (instr_valid),
    .out_valid                  (out_valid),
    .opcode                     (opcode),
    .read_i1_write_i            (read_i1_write_i),
    .five_to_one                (five_to_one),
    .read_i2_write_d_write_data (read_i2_write_d_write_data),
    .one_to_zero                (one_to_zero),
    .arg2                       (arg2),
    .bit0                       (bit0),
    .opcode_onehot              (opcode_onehot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string step);
    chk({step, ":out_valid"}, 16'(out_valid), 16'(m_valid));
    chk({step, ":opcode"},    16'(opcode), 16'(m_instr / 64));
    chk({step, ":ri1"},       16'(read_i1_write_i), 16'((m_instr / 4) % 16));
    chk({step, ":f51"},       16'(five_to_one), 16'((m_instr / 2) % 32));
    chk({step, ":ri2"},       16'(read_i2_write_d_write_data), 16'(m_instr % 64));
    chk({step, ":f10"},       16'(one_to_zero), 16'(m_instr % 4));
    chk({step, ":arg2"},      16'(arg2), 16'((m_instr / 2) % 2));
    chk({step, ":bit0"},      16'(bit0), 16'(m_instr % 2));
    chk({step, ":onehot"},    opcode_onehot, 16'(m_onehot));
  endtask

  // Drive one cycle, advance the model, and check outputs just after the edge.
  task automatic step(input string name, input logic r, input logic v, input logic [9:0] i);
    rst         = r;
    instr_valid = v;
    instr       = i;
    @(posedge clk);
    if (r) begin
      m_instr = 0; m_valid = 0; m_onehot = 0;
    end else if (v) begin
      m_instr = int'(i); m_valid = 1; m_onehot = 1 << (int'(i) / 64);
    end else begin
      m_valid = 0;
    end
    #1;
    check_all(name);
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b1; instr = 10'h3FF;
    #1;
    step("reset0", 1'b1, 1'b1, 10'h3FF);
    step("reset1", 1'b1, 1'b1, 10'h3FF);

    step("i15",  1'b0, 1'b1, 10'd15);
    chk("i15:onehot_lit", opcode_onehot, 16'h0001);
    step("i20",  1'b0, 1'b1, 10'd20);
    step("i500", 1'b0, 1'b1, 10'd500);
    chk("i500:onehot_lit", opcode_onehot, 16'h0080);
    chk("i500:ri2_lit", 16'(read_i2_write_d_write_data), 16'd52);

    step("hold", 1'b0, 1'b0, 10'h3C0);
    chk("hold:opcode_lit", 16'(opcode), 16'd7);
    step("i3C0", 1'b0, 1'b1, 10'h3C0);
    chk("i3C0:onehot_lit", opcode_onehot, 16'h8000);

    step("b2b15",  1'b0, 1'b1, 10'd15);
    step("b2b20",  1'b0, 1'b1, 10'd20);
    step("b2b500", 1'b0, 1'b1, 10'd500);
    step("rstpri", 1'b1, 1'b1, 10'h3FF);
    chk("rstpri:onehot_lit", opcode_onehot, 16'h0000);

    for (int k = 0; k < 16; k++) begin
      step("allopc", 1'b0, 1'b1, 10'(k * 64 + 37));
    end

    for (int k = 0; k < 300; k++) begin
      logic r, v;
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 9) < 7);
      step("rand", r, v, 10'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
